// File: rtl/wave_period_meter_pkg.sv
// Shared types and constants for the waveform period meter.
// Sample width, default crossing level and hysteresis, FSM state encoding.
// Threshold helpers clamp MID +/- HYST into the 8-bit sample range.
package wave_period_meter_pkg;

  localparam int SAMPLE_W = 8;
  localparam int MID_DEF  = 128;
  localparam int HYST_DEF = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    HUNT    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Upper threshold MID+HYST, saturating at full scale.
  function automatic sample_t thr_hi(input int mid, input int hyst);
    logic [SAMPLE_W:0] s;
    s = (SAMPLE_W+1)'(mid) + (SAMPLE_W+1)'(hyst);
    return s[SAMPLE_W] ? {SAMPLE_W{1'b1}} : s[SAMPLE_W-1:0];
  endfunction

  // Lower threshold MID-HYST, saturating at zero (borrow bit set means underflow).
  function automatic sample_t thr_lo(input int mid, input int hyst);
    logic [SAMPLE_W:0] d;
    d = (SAMPLE_W+1)'(mid) - (SAMPLE_W+1)'(hyst);
    return d[SAMPLE_W] ? '0 : d[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/wave_hyst_cmp.sv
// Hysteresis comparator: tracks the high/low flag and flags rising crossings.
// Latency: rise_o is combinational on the current sample; flags update next clock.
// Backpressure: none; only cycles with sample_vld_i advance state.
module wave_hyst_cmp
  import wave_period_meter_pkg::*;
#(
  parameter int MID  = MID_DEF,
  parameter int HYST = HYST_DEF
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  sample_t sample_i,
  input  logic    sample_vld_i,
  output logic    rise_o
);

  localparam sample_t HI_TH = thr_hi(MID, HYST);
  localparam sample_t LO_TH = thr_lo(MID, HYST);
  localparam sample_t MID_S = sample_t'(MID);

  logic primed_q, primed_d;
  logic hi_q, hi_d;

  // The very first sample only seeds the flag, so power-up level never counts as a crossing.
  assign rise_o = sample_vld_i & primed_q & ~hi_q & (sample_i >= HI_TH);

  // Next-state of the priming and high/low flags.
  always_comb begin
    primed_d = primed_q;
    hi_d     = hi_q;
    if (sample_vld_i) begin
      if (!primed_q) begin
        primed_d = 1'b1;
        hi_d     = (sample_i >= MID_S);
      end else if (sample_i >= HI_TH) begin
        hi_d = 1'b1;
      end else if (sample_i <= LO_TH) begin
        hi_d = 1'b0;
      end
    end
  end

  // Flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      primed_q <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      primed_q <= primed_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: rtl/wave_period_meter.sv
// Measures period, max and min of each cycle between rising mid-level crossings.
// Latency: result_valid/timeout pulse one clock after the deciding sample is accepted.
// Backpressure: none; gaps in sample_valid are invisible to the measurement.
module wave_period_meter
  import wave_period_meter_pkg::*;
#(
  parameter int MID        = MID_DEF,
  parameter int HYST       = HYST_DEF,
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [SAMPLE_W-1:0] peak_max,
  output logic [SAMPLE_W-1:0] peak_min,
  output logic                result_valid,
  output logic                timeout
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

  logic rise;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  sample_t             run_max_q, run_max_d;
  sample_t             run_min_q, run_min_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  sample_t             peak_max_q, peak_max_d;
  sample_t             peak_min_q, peak_min_d;
  logic                rv_q, rv_d;
  logic                to_q, to_d;

  wave_hyst_cmp #(
    .MID  (MID),
    .HYST (HYST)
  ) u_cmp (
    .clk_i        (clk),
    .rst_i        (rst),
    .sample_i     (sample_in),
    .sample_vld_i (sample_valid),
    .rise_o       (rise)
  );

  // FSM next-state, counter, running extremes and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_max_d  = run_max_q;
    run_min_d  = run_min_q;
    period_d   = period_q;
    peak_max_d = peak_max_q;
    peak_min_d = peak_min_q;
    rv_d       = 1'b0;
    to_d       = 1'b0;
    if (sample_valid) begin
      case (state_q)
        HUNT: begin
          if (rise) begin
            state_d   = MEASURE;
            cnt_d     = ONE;
            run_max_d = sample_in;
            run_min_d = sample_in;
          end
        end
        MEASURE: begin
          if (rise && (cnt_q >= MIN_P)) begin
            // Crossing sample closes this cycle and opens the next one.
            period_d   = cnt_q;
            peak_max_d = run_max_q;
            peak_min_d = run_min_q;
            rv_d       = 1'b1;
            cnt_d      = ONE;
            run_max_d  = sample_in;
            run_min_d  = sample_in;
          end else if (!rise && (&cnt_q)) begin
            // Counter saturated: abandon the cycle, keep last result visible.
            to_d    = 1'b1;
            state_d = HUNT;
            cnt_d   = '0;
          end else begin
            // Ordinary sample, including a too-early crossing treated as noise.
            cnt_d     = cnt_q + ONE;
            run_max_d = (sample_in > run_max_q) ? sample_in : run_max_q;
            run_min_d = (sample_in < run_min_q) ? sample_in : run_min_q;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      run_max_q  <= '0;
      run_min_q  <= '0;
      period_q   <= '0;
      peak_max_q <= '0;
      peak_min_q <= '0;
      rv_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_max_q  <= run_max_d;
      run_min_q  <= run_min_d;
      period_q   <= period_d;
      peak_max_q <= peak_max_d;
      peak_min_q <= peak_min_d;
      rv_q       <= rv_d;
      to_q       <= to_d;
    end
  end

  assign period       = period_q;
  assign peak_max     = peak_max_q;
  assign peak_min     = peak_min_q;
  assign result_valid = rv_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_wave_period_meter.sv
// Bench for wave_period_meter: two instances (16-bit and 6-bit period counter)
// share one stimulus stream; a sample-history reference model predicts every
// result/timeout pulse into per-instance queues checked by a negedge monitor.
module tb_wave_period_meter;

  localparam int HI_TH = 136;
  localparam int LO_TH = 120;
  localparam int MINP  = 4;
  localparam int PW_A  = 16;
  localparam int PW_B  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  sample_in;
  logic        sample_valid;

  logic [15:0] period_a;
  logic [7:0]  pmax_a, pmin_a;
  logic        rv_a, to_a;
  logic [5:0]  period_b;
  logic [7:0]  pmax_b, pmin_b;
  logic        rv_b, to_b;

  wave_period_meter #(.PERIOD_W(PW_A)) u_dut_a (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .period(period_a), .peak_max(pmax_a), .peak_min(pmin_a),
    .result_valid(rv_a), .timeout(to_a)
  );

  wave_period_meter #(.PERIOD_W(PW_B)) u_dut_b (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .period(period_b), .peak_max(pmax_b), .peak_min(pmin_b),
    .result_valid(rv_b), .timeout(to_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = result, 1 = timeout
    int cyc;
    int per;
    int mx;
    int mn;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Every accepted sample since time zero; cycles are index ranges into it.
  int hist[$];
  bit primed[2];
  bit hi[2];
  bit meas[2];
  int start[2];
  int lp[2], lmx[2], lmn[2];

  function automatic int pw_of(input int k);
    return (k == 0) ? PW_A : PW_B;
  endfunction

  function automatic string tag(input int k);
    return (k == 0) ? "w16" : "w6";
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input exp_t e);
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Reference: cycle = samples from one accepted crossing up to the next;
  // extremes found by scanning the recorded history of that cycle.
  task automatic model_step(input int k, input int s);
    int   idx, len, mx, mn, full;
    bit   rise;
    exp_t e;
    idx  = hist.size();
    rise = primed[k] && !hi[k] && (s >= HI_TH);
    if (!primed[k]) begin
      primed[k] = 1'b1;
      hi[k]     = (s >= 128);
    end else if (s >= HI_TH) begin
      hi[k] = 1'b1;
    end else if (s <= LO_TH) begin
      hi[k] = 1'b0;
    end
    full = (1 << pw_of(k)) - 1;
    if (!meas[k]) begin
      if (rise) begin
        meas[k]  = 1'b1;
        start[k] = idx;
      end
    end else begin
      len = idx - start[k];
      if (rise && len >= MINP) begin
        mx = 0;
        mn = 255;
        for (int i = start[k]; i < idx; i++) begin
          if (hist[i] > mx) mx = hist[i];
          if (hist[i] < mn) mn = hist[i];
        end
        lp[k]  = len;
        lmx[k] = mx;
        lmn[k] = mn;
        e = '{0, cyc + 1, len, mx, mn};
        push_exp(k, e);
        start[k] = idx;
      end else if (!rise && len == full) begin
        e = '{1, cyc + 1, lp[k], lmx[k], lmn[k]};
        push_exp(k, e);
        meas[k] = 1'b0;
      end
    end
  endtask

  task automatic send(input int s, input bit v);
    sample_in    = 8'(s);
    sample_valid = v;
    if (v) begin
      model_step(0, s);
      model_step(1, s);
      hist.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      primed[k] = 1'b0;
      hi[k]     = 1'b0;
      meas[k]   = 1'b0;
      lp[k]     = 0;
      lmx[k]    = 0;
      lmn[k]    = 0;
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    sample_valid = 1'b0;
    check("rst.w16.period", int'(period_a), 0);
    check("rst.w16.peak_max", int'(pmax_a), 0);
    check("rst.w16.peak_min", int'(pmin_a), 0);
    check("rst.w16.result_valid", int'(rv_a), 0);
    check("rst.w16.timeout", int'(to_a), 0);
    check("rst.w6.period", int'(period_b), 0);
    check("rst.w6.peak_max", int'(pmax_b), 0);
    check("rst.w6.peak_min", int'(pmin_b), 0);
    check("rst.w6.result_valid", int'(rv_b), 0);
    check("rst.w6.timeout", int'(to_b), 0);
  endtask

  task automatic mon(input int k, input bit rv, input bit to,
                     input int per, input int mx, input int mn);
    exp_t e;
    bit   empty;
    if (rv || to) begin
      check({tag(k), ".pulse_exclusive"}, int'(rv && to), 0);
      empty = (k == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      if (empty) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s.unexpected_pulse: got result_valid=%0d timeout=%0d, expected none (t=%0t)",
                 tag(k), rv, to, $time);
      end else begin
        if (k == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
        check({tag(k), ".kind"}, int'(to), e.kind);
        check({tag(k), ".cycle"}, cyc, e.cyc);
        check({tag(k), ".period"}, per, e.per);
        check({tag(k), ".peak_max"}, mx, e.mx);
        check({tag(k), ".peak_min"}, mn, e.mn);
      end
    end
  endtask

  // Monitor, sampled away from the active edge.
  always @(negedge clk) begin
    mon(0, rv_a, to_a, int'(period_a), int'(pmax_a), int'(pmin_a));
    mon(1, rv_b, to_b, int'(period_b), int'(pmax_b), int'(pmin_b));
  end

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    // First sample after reset is high: primes only, no event.
    send(255, 1'b1);

    // Square wave, 16 low / 16 high, continuous valid.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) send(0, 1'b1);
      for (int i = 0; i < 16; i++) send(255, 1'b1);
    end

    // Sawtooth, valid every third clock.
    for (int r = 0; r < 3 * 256 + 10; r++) begin
      send(r % 256, 1'b1);
      send(0, 1'b0);
      send(0, 1'b0);
    end

    // Glitch: early re-crossing, then clean cycles.
    for (int i = 0; i < 10; i++) send(0, 1'b1);
    send(255, 1'b1);
    send(8'h70, 1'b1);
    send(8'h90, 1'b1);
    for (int i = 0; i < 17; i++) send(255, 1'b1);
    for (int i = 0; i < 20; i++) send(0, 1'b1);
    send(255, 1'b1);
    for (int i = 0; i < 19; i++) send(255, 1'b1);
    for (int i = 0; i < 20; i++) send(0, 1'b1);
    send(255, 1'b1);

    // Long flat low: the narrow counter saturates; then restart.
    for (int i = 0; i < 100; i++) send(0, 1'b1);
    for (int i = 0; i < 20; i++) send(200, 1'b1);
    for (int i = 0; i < 20; i++) send(0, 1'b1);
    for (int i = 0; i < 10; i++) send(200, 1'b1);
    for (int i = 0; i < 10; i++) send(0, 1'b1);
    send(200, 1'b1);

    // Random noisy segments with random valid gaps.
    for (int seg = 0; seg < 150; seg++) begin
      int dur;
      bit up;
      dur = $urandom_range(1, 45);
      up  = seg[0];
      for (int i = 0; i < dur; i++) begin
        int s;
        s = up ? $urandom_range(100, 255) : $urandom_range(0, 150);
        send(s, $urandom_range(0, 3) != 0);
      end
    end

    // Reset mid-cycle with valid asserted; then a high first sample.
    for (int i = 0; i < 10; i++) send(255, 1'b1);
    for (int i = 0; i < 5; i++) send(0, 1'b1);
    do_reset();
    send(255, 1'b1);
    send(255, 1'b1);
    for (int i = 0; i < 8; i++) send(0, 1'b1);

    // Dither inside the hysteresis band after a low prime: never a crossing.
    do_reset();
    send(0, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      send(130, 1'b1);
      send(126, 1'b1);
    end

    // Drain and confirm every predicted pulse appeared.
    for (int i = 0; i < 4; i++) send(0, 1'b0);
    check("w16.pending_expected", q_a.size(), 0);
    check("w6.pending_expected", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
